// File: rtl/dct_sched_pkg.sv
// DCT strip scheduler shared types.
// FSM states, default sizes, vector count helper.
package dct_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_N  = 8;
  localparam int DEF_DW = 17;

  function automatic int total_vecs(
    input int w,
    input int h,
    input int n
  );
    return (w / n) * h;
  endfunction

endpackage

// File: rtl/dct_vec_packer.sv
// Lane capture register for the DCT input vector.
// Writes one returned memory word into its lane.
module dct_vec_packer #(
  parameter int N  = 8,
  parameter int DW = 17,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap_en,
  input  logic [LW-1:0]   lane,
  input  logic [DW-1:0]   rdata,
  output logic [N*DW-1:0] vec
);

  logic [N-1:0][DW-1:0] lanes;

  // capture the word returned for the lane read last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes <= '0;
    end else if (cap_en) begin
      lanes[lane] <= rdata;
    end
  end

  assign vec = lanes;

endmodule

// File: rtl/dct_strip_scheduler.sv
// Full-image strip scan feeding the 8-point DCT.
// Fetches N-sample vectors, hands them off, counts results.
module dct_strip_scheduler
  import dct_sched_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int AW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_rdata,
  output logic [N*DW-1:0] vec_data,
  output logic            vec_valid,
  input  logic            vec_ready,
  input  logic            crdy,
  output logic [AW-1:0]   coef_cnt
);

  localparam int TOTAL = total_vecs(IMG_W, IMG_H, N);
  localparam int NS    = IMG_W / N;
  localparam int SW    = (NS > 1) ? $clog2(NS) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KW    = $clog2(N + 1);
  localparam int LW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [AW-1:0] TOTAL_A = AW'(TOTAL);
  localparam logic [SW-1:0] S_LAST  = SW'(NS - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 1);
  localparam logic [KW-1:0] K_END   = KW'(N);

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   s;
  logic [RW-1:0]   r;
  logic [KW-1:0]   fcnt;
  logic [AW-1:0]   addr_calc;
  logic [AW-1:0]   addr_hold;
  logic            cap_en;
  logic [LW-1:0]   cap_lane;
  logic            xfer;
  logic            last_vec;
  logic            start_ok;
  logic            cnt_full;

  assign xfer     = (state == PRESENT) && vec_ready;
  assign last_vec = (s == S_LAST) && (r == R_LAST);
  assign start_ok = (state == IDLE) && start;
  assign cnt_full = (coef_cnt == TOTAL_A);

  assign addr_calc = AW'(r) * AW'(IMG_W)
                   + AW'(s) * AW'(N)
                   + AW'(fcnt);

  assign mem_addr = mem_rd ? addr_calc : addr_hold;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        if (fcnt == K_END) state_nx = PRESENT;
      end
      PRESENT: begin
        if (vec_ready) begin
          state_nx = last_vec ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (cnt_full) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    mem_rd    = (state == FETCH) && (fcnt != K_END);
    vec_valid = (state == PRESENT);
    done      = (state == DONE);
    busy      = (state == FETCH)
             || (state == PRESENT)
             || (state == DRAIN);
  end

  // fetch counter, address hold and capture delay
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt      <= '0;
      addr_hold <= '0;
      cap_en    <= 1'b0;
      cap_lane  <= '0;
    end else begin
      cap_en   <= mem_rd;
      cap_lane <= fcnt[LW-1:0];
      if (mem_rd) addr_hold <= addr_calc;
      if ((state == FETCH) && (fcnt != K_END)) begin
        fcnt <= fcnt + KW'(1);
      end else begin
        fcnt <= '0;
      end
    end
  end

  // strip/row scan indices
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
      r <= '0;
    end else if (start_ok) begin
      s <= '0;
      r <= '0;
    end else if (xfer && !last_vec) begin
      if (r == R_LAST) begin
        r <= '0;
        s <= s + SW'(1);
      end else begin
        r <= r + RW'(1);
      end
    end
  end

  // coefficient-ready counter, saturating at the vector total
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_cnt <= '0;
    end else if (start_ok) begin
      coef_cnt <= '0;
    end else if ((state != IDLE) && crdy && !cnt_full) begin
      coef_cnt <= coef_cnt + AW'(1);
    end
  end

  dct_vec_packer #(
    .N  (N),
    .DW (DW),
    .LW (LW)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .cap_en (cap_en),
    .lane   (cap_lane),
    .rdata  (mem_rdata),
    .vec    (vec_data)
  );

endmodule
